// File: rtl/joy_input_conditioner.sv
// Joystick button conditioner: 2-FF sync, per-bit debounce, press one-shots,
// and typematic auto-repeat on the four cursor directions, muted while the OSD is open.
module joy_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 15000000,
  parameter int REPEAT_RATE     = 4000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] joy_raw,
  input  logic       osd_active,
  output logic [8:0] btn_held,
  output logic [8:0] btn_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [8:0]    sync_p0;
  logic [8:0]    sync_p1;
  logic [8:0]    stable;
  logic [8:0]    held_prev;
  logic [DW-1:0] db_cnt [9];

  logic [1:0]    state;
  logic [1:0]    owner;
  logic [1:0]    new_owner;
  logic [RW-1:0] rc;
  logic [RW-1:0] rc_last;
  logic [8:0]    rise;
  logic [3:0]    dir_rise;
  logic [3:0]    rep_vec;
  logic          rep_fire;

  // Stage p0/p1: synchroniser, then debounce into stable, then registered level
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable    <= '0;
      btn_held  <= '0;
      held_prev <= '0;
      for (int i = 0; i < 9; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0 <= joy_raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 9; i++) begin
        if (sync_p1[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
      btn_held  <= stable;
      held_prev <= btn_held;
    end
  end

  // A fresh press edge on any direction pre-empts a repeat pulse in the same cycle
  always_comb begin
    rise      = btn_held & ~held_prev;
    dir_rise  = rise[3:0];
    new_owner = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (dir_rise[i]) new_owner = 2'(i);
    end
    rc_last   = (state == S_DELAY) ? DELAY_LAST : RATE_LAST;
    rep_fire  = (state != S_IDLE) && btn_held[owner] && (dir_rise == 4'd0) && (rc == rc_last);
    rep_vec   = rep_fire ? (4'b0001 << owner) : 4'b0000;
    btn_pulse = osd_active ? 9'd0 : (rise | {5'd0, rep_vec});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      owner <= 2'd0;
      rc    <= '0;
    end else if (osd_active) begin
      state <= S_IDLE;
      rc    <= '0;
    end else if (dir_rise != 4'd0) begin
      state <= S_DELAY;
      owner <= new_owner;
      rc    <= '0;
    end else if (state != S_IDLE) begin
      if (!btn_held[owner]) begin
        state <= S_IDLE;
        rc    <= '0;
      end else if (rc == rc_last) begin
        state <= S_REPEAT;
        rc    <= '0;
      end else begin
        rc <= rc + RW'(1);
      end
    end
  end

endmodule
